// File: rtl/cubic_feeder.sv
// Request sequencer for the 4-tap bicubic engine: builds {t,t^2,t^3}, fetches the
// four edge-clamped taps from a 1-cycle line memory and returns the engine result.
module cubic_feeder #(
    parameter int LINE_LEN = 256,
    parameter int ADDR_W   = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [7:0]        req_frac,
    input  logic [ADDR_W-1:0] req_idx,
    output logic              mem_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_rdata,
    output logic [2:0]        eng_cycle_cnt,
    output logic [23:0]       eng_X_in,
    output logic [7:0]        eng_P_in,
    input  logic [7:0]        eng_out,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [7:0]        res_data
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_F1   = 3'd2,
        S_F2   = 3'd3,
        S_F3   = 3'd4,
        S_F4   = 3'd5,
        S_CAP  = 3'd6,
        S_RESP = 3'd7
    } state_t;

    localparam logic signed [ADDR_W+1:0] MAX_TAP = (ADDR_W+2)'(LINE_LEN - 1);

    // Tap address idx+j evaluated signed with two guard bits, clamped to the line.
    function automatic logic [ADDR_W-1:0] tap_addr(input logic [ADDR_W-1:0] idx,
                                                   input logic signed [2:0] j);
        logic signed [ADDR_W+1:0] sum;
        logic [ADDR_W-1:0]        res;
        sum = $signed({2'b00, idx}) + $signed({{(ADDR_W-1){j[2]}}, j});
        if (sum < $signed({(ADDR_W+2){1'b0}})) begin
            res = {ADDR_W{1'b0}};
        end else if (sum > MAX_TAP) begin
            res = MAX_TAP[ADDR_W-1:0];
        end else begin
            res = sum[ADDR_W-1:0];
        end
        return res;
    endfunction

    // Round-half-up Q0.8 powers; t=255 peaks at 65153, so 16 bits never overflow.
    function automatic logic [23:0] weights(input logic [7:0] t);
        logic [15:0] p2;
        logic [15:0] p3;
        logic [7:0]  t2;
        logic [7:0]  t3;
        p2 = 16'(t) * 16'(t) + 16'd128;
        t2 = 8'(p2 >> 8);
        p3 = 16'(t2) * 16'(t) + 16'd128;
        t3 = 8'(p3 >> 8);
        return {t, t2, t3};
    endfunction

    state_t            state_q, state_d;
    logic [23:0]       x_q, x_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [7:0]        res_data_q, res_data_d;
    logic              res_valid_q, res_valid_d;

    // State and datapath registers; reset aborts any request in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            x_q         <= 24'd0;
            idx_q       <= {ADDR_W{1'b0}};
            res_data_q  <= 8'd0;
            res_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            idx_q       <= idx_d;
            res_data_q  <= res_data_d;
            res_valid_q <= res_valid_d;
        end
    end

    // Next-state and datapath update.
    always_comb begin
        state_d     = state_q;
        x_d         = x_q;
        idx_d       = idx_q;
        res_data_d  = res_data_q;
        res_valid_d = res_valid_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    x_d     = weights(req_frac);
                    idx_d   = req_idx;
                    state_d = S_LOAD;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_LOAD: state_d = S_F1;
            S_F1:   state_d = S_F2;
            S_F2:   state_d = S_F3;
            S_F3:   state_d = S_F4;
            S_F4:   state_d = S_CAP;
            S_CAP: begin
                res_data_d  = eng_out;
                res_valid_d = 1'b1;
                state_d     = S_RESP;
            end
            S_RESP: begin
                if (res_ready) begin
                    res_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end else begin
                    state_d = S_RESP;
                end
            end
            default: begin
                res_valid_d = 1'b0;
                state_d     = S_IDLE;
            end
        endcase
    end

    // Per-state outputs; memory reads run one tap ahead of the engine phase.
    always_comb begin
        req_ready     = 1'b0;
        mem_en        = 1'b0;
        mem_addr      = {ADDR_W{1'b0}};
        eng_cycle_cnt = 3'd1;
        case (state_q)
            S_IDLE: begin
                req_ready     = 1'b1;
                eng_cycle_cnt = 3'd1;
            end
            S_LOAD: begin
                eng_cycle_cnt = 3'd0;
                mem_en        = 1'b1;
                mem_addr      = tap_addr(idx_q, 3'sb111);
            end
            S_F1: begin
                eng_cycle_cnt = 3'd1;
                mem_en        = 1'b1;
                mem_addr      = tap_addr(idx_q, 3'sb000);
            end
            S_F2: begin
                eng_cycle_cnt = 3'd2;
                mem_en        = 1'b1;
                mem_addr      = tap_addr(idx_q, 3'sb001);
            end
            S_F3: begin
                eng_cycle_cnt = 3'd3;
                mem_en        = 1'b1;
                mem_addr      = tap_addr(idx_q, 3'sb010);
            end
            S_F4:    eng_cycle_cnt = 3'd4;
            S_CAP:   eng_cycle_cnt = 3'd0;
            S_RESP:  eng_cycle_cnt = 3'd1;
            default: eng_cycle_cnt = 3'd1;
        endcase
    end

    assign eng_X_in  = x_q;
    assign eng_P_in  = mem_rdata;
    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;

endmodule
